// File: rtl/jtbubl_pkg.sv
// Shared types and widths for the ROM request slots.
package jtbubl_pkg;
  localparam int SDRAM_AW = 22;
  localparam int LINE_W   = 32;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/jtbubl_romrq_if.sv
// Client + arbiter bus of one ROM request slot.
interface jtbubl_romrq_if
  import jtbubl_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 8
);
  logic                clr;
  logic                cs;
  logic [AW-1:0]       addr;
  logic [DW-1:0]       dout;
  logic                data_ok;
  logic                req;
  logic [SDRAM_AW-1:0] req_addr;
  logic                we;
  logic                data_rdy;
  logic [LINE_W-1:0]   din;

  modport slave (
    input  clr, cs, addr, we, data_rdy, din,
    output dout, data_ok, req, req_addr
  );

  modport master (
    output clr, cs, addr, we, data_rdy, din,
    input  dout, data_ok, req, req_addr
  );
endinterface

// File: rtl/jtbubl_romrq_line.sv
// One cache entry: tag, valid flag and a 32-bit SDRAM word, with hit compare.
module jtbubl_romrq_line
  import jtbubl_pkg::*;
#(
  parameter int TW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr,
  input  logic [TW-1:0]     wtag,
  input  logic [LINE_W-1:0] wdata,
  input  logic [TW-1:0]     cmp_tag,
  output logic              hit,
  output logic [LINE_W-1:0] data
);
  logic          valid;
  logic [TW-1:0] tag;

  // clr beats a same-edge write so a download never leaves stale lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      tag   <= wtag;
      data  <= wdata;
    end
  end

  assign hit = valid && (tag == cmp_tag);
endmodule

// File: rtl/jtbubl_romrq.sv
// ROM read slot: 2-entry line cache in front of the SDRAM arbiter.
module jtbubl_romrq
  import jtbubl_pkg::*;
#(
  parameter int                  AW     = 18,
  parameter int                  DW     = 8,
  parameter logic [SDRAM_AW-1:0] OFFSET = '0
) (
  input logic            clk,
  input logic            rst_n,
  jtbubl_romrq_if.slave  bus
);
  localparam int SW = $clog2(LINE_W / DW);
  localparam int TW = AW - SW;

  state_t                 st, st_nxt;
  logic [TW-1:0]          addr_tag, pend_tag;
  logic                   discard, victim;
  logic [1:0]             hit;
  logic [1:0][LINE_W-1:0] ldata;
  logic                   hit_any, hit_idx, hit_now;
  logic                   fill, wr_en, wsel;
  logic [LINE_W-1:0]      word;

  assign addr_tag = bus.addr[AW-1:SW];
  assign hit_any  = |hit;
  assign hit_idx  = hit[1];
  assign hit_now  = bus.cs && !bus.clr && hit_any;
  assign fill     = (st == WAIT) && bus.we && bus.data_rdy;
  assign wr_en    = fill && !discard && !bus.clr;
  // never overwrite the entry the client is reading this cycle
  assign wsel     = hit_now ? ~hit_idx : victim;

  for (genvar i = 0; i < 2; i++) begin : g_line
    jtbubl_romrq_line #(.TW(TW)) u_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (bus.clr),
      .wr      (wr_en && (wsel == 1'(i))),
      .wtag    (pend_tag),
      .wdata   (bus.din),
      .cmp_tag (addr_tag),
      .hit     (hit[i]),
      .data    (ldata[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (bus.cs && !bus.clr && !hit_any) st_nxt = REQ;
      REQ:     if (bus.we)                         st_nxt = WAIT;
      WAIT:    if (bus.we && bus.data_rdy)         st_nxt = IDLE;
      default: st_nxt = IDLE;
    endcase
  end

  // discard marks a fill whose contents were invalidated by clr mid-flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_tag <= '0;
      discard  <= 1'b0;
      victim   <= 1'b0;
    end else begin
      if (st == IDLE && st_nxt == REQ) begin
        pend_tag <= addr_tag;
        discard  <= 1'b0;
      end else if (bus.clr && st != IDLE) begin
        discard  <= 1'b1;
      end
      if (wr_en)        victim <= ~wsel;
      else if (hit_now) victim <= ~hit_idx;
    end
  end

  assign bus.req      = (st == REQ);
  assign bus.req_addr = OFFSET + SDRAM_AW'({pend_tag, 1'b0});
  assign bus.data_ok  = hit_now;
  assign word         = hit[1] ? ldata[1] : ldata[0];

  if (SW == 0) begin : g_full
    assign bus.dout = bus.data_ok ? word[DW-1:0] : '0;
  end else begin : g_sub
    logic [SW-1:0] sub;
    assign sub      = bus.addr[SW-1:0];
    assign bus.dout = bus.data_ok ? word[DW*32'(sub) +: DW] : '0;
  end
endmodule

// File: tb/tb_jtbubl_romrq.sv
// Bench for jtbubl_romrq: acts as client and arbiter, scoreboards returned data.
module tb_jtbubl_romrq;
  import jtbubl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtbubl_romrq_if #(.AW(18), .DW(8))  b8();
  jtbubl_romrq_if #(.AW(18), .DW(32)) b32();

  jtbubl_romrq #(.AW(18), .DW(8), .OFFSET(22'h000000)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.slave)
  );
  jtbubl_romrq #(.AW(18), .DW(32), .OFFSET(22'h3FFFFE)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // land one cycle later, away from the rising edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // wait for data_ok (bounded), then pop the oldest expected byte and compare
  task automatic expect_data(input string tag, input int budget);
    int n = 0;
    while (!b8.data_ok && n < budget) begin tick(); n++; end
    chk({tag, "_ok"}, 32'(b8.data_ok), 32'd1);
    if (exp_q.size() > 0) chk({tag, "_dout"}, 32'(b8.dout), exp_q.pop_front());
  endtask

  // arbiter side for the DW=8 slot: grant, then deliver d
  task automatic serve(input string tag, input logic [21:0] exp_ra, input logic [31:0] d);
    int n = 0;
    while (!b8.req && n < 20) begin tick(); n++; end
    chk({tag, "_req"}, 32'(b8.req), 32'd1);
    chk({tag, "_ra"}, 32'(b8.req_addr), 32'(exp_ra));
    b8.we = 1'b1;
    tick();
    chk({tag, "_reqdrop"}, 32'(b8.req), 32'd0);
    b8.data_rdy = 1'b1;
    b8.din      = d;
    tick();
    b8.we = 1'b0;
    b8.data_rdy = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] w;
    {b8.clr, b8.cs, b8.addr, b8.we, b8.data_rdy, b8.din} = '0;
    {b32.clr, b32.cs, b32.addr, b32.we, b32.data_rdy, b32.din} = '0;

    // reset state
    b8.cs = 1'b1;
    #2;
    chk("rst_req", 32'(b8.req), 32'd0);
    chk("rst_ok", 32'(b8.data_ok), 32'd0);
    chk("rst_dout", 32'(b8.dout), 32'd0);
    b8.cs = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: miss on byte 5 -> line tag 1 -> word 2
    b8.cs = 1'b1;
    b8.addr = 18'h00005;
    exp_q.push_back(32'hBB);
    #1;
    chk("t1_miss_ok", 32'(b8.data_ok), 32'd0);
    chk("t1_req_early", 32'(b8.req), 32'd0);
    tick();
    chk("t1_req_lat", 32'(b8.req), 32'd1);
    serve("t1", 22'h000002, 32'hDDCCBBAA);
    expect_data("t1", 0);

    // 2: hits on the filled line, little-endian bytes
    w = 32'hDDCCBBAA;
    for (int i = 4; i < 8; i++) begin
      b8.addr = 18'(i);
      exp_q.push_back(32'((w >> (8 * (i - 4))) & 32'hFF));
      #1;
      expect_data($sformatf("t2_%0d", i), 0);
      chk($sformatf("t2_noreq_%0d", i), 32'(b8.req), 32'd0);
      tick();
    end

    // 3: tags 1/2 cached, touch 1, miss tag 3 evicts tag 2
    b8.addr = 18'h00008;
    exp_q.push_back(32'h11);
    #1;
    chk("t3a_miss", 32'(b8.data_ok), 32'd0);
    serve("t3a", 22'h000004, 32'h44332211);
    expect_data("t3a", 0);
    b8.addr = 18'h00004;
    exp_q.push_back(32'hAA);
    #1;
    expect_data("t3_touch1", 0);
    tick();
    b8.addr = 18'h0000C;
    exp_q.push_back(32'h55);
    serve("t3b", 22'h000006, 32'h88776655);
    expect_data("t3b", 0);
    b8.addr = 18'h00004;
    exp_q.push_back(32'hAA);
    #1;
    expect_data("t3_keep1", 0);
    tick();
    b8.addr = 18'h00008;
    #1;
    chk("t3_evict_ok", 32'(b8.data_ok), 32'd0);
    tick();
    chk("t3_evict_req", 32'(b8.req), 32'd1);
    // hit on the other entry while the miss is outstanding
    b8.addr = 18'h00004;
    exp_q.push_back(32'hAA);
    #1;
    expect_data("t3_hit_in_req", 0);
    serve("t3c", 22'h000004, 32'h44332211);
    b8.addr = 18'h00008;
    exp_q.push_back(32'h11);
    #1;
    expect_data("t3c", 0);
    tick();

    // 4: clr while waiting discards the fill, same addr re-requests
    b8.addr = 18'h00010;
    tick();
    chk("t4_req", 32'(b8.req), 32'd1);
    chk("t4_ra", 32'(b8.req_addr), 32'h000008);
    b8.we = 1'b1;
    tick();
    b8.clr = 1'b1;
    b8.addr = 18'h00004;
    #1;
    chk("t4_clr_ok", 32'(b8.data_ok), 32'd0);
    b8.addr = 18'h00010;
    tick();
    b8.clr = 1'b0;
    b8.data_rdy = 1'b1;
    b8.din = 32'h11111111;
    tick();
    b8.we = 1'b0;
    b8.data_rdy = 1'b0;
    #1;
    chk("t4_discard", 32'(b8.data_ok), 32'd0);
    b8.addr = 18'h00004;
    #1;
    chk("t4_cleared", 32'(b8.data_ok), 32'd0);
    b8.addr = 18'h00010;
    tick();
    chk("t4_rereq", 32'(b8.req), 32'd1);
    chk("t4_rera", 32'(b8.req_addr), 32'h000008);
    exp_q.push_back(32'h0D);
    serve("t4b", 22'h000008, 32'hCAFEF00D);
    expect_data("t4b", 0);

    // 5: DW=32 slot, OFFSET wraps to 0
    b32.cs = 1'b1;
    b32.addr = 18'h00001;
    #1;
    chk("t5_miss", 32'(b32.data_ok), 32'd0);
    tick();
    chk("t5_req", 32'(b32.req), 32'd1);
    chk("t5_ra", 32'(b32.req_addr), 32'h000000);
    b32.we = 1'b1;
    tick();
    b32.data_rdy = 1'b1;
    b32.din = 32'h12345678;
    tick();
    b32.we = 1'b0;
    b32.data_rdy = 1'b0;
    #1;
    chk("t5_ok", 32'(b32.data_ok), 32'd1);
    chk("t5_dout", b32.dout, 32'h12345678);

    // 6: reset mid-request
    b8.addr = 18'h00014;
    tick();
    chk("t6_req", 32'(b8.req), 32'd1);
    b8.addr = 18'h00010;
    #1;
    chk("t6_hit_pre", 32'(b8.data_ok), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_req_rst", 32'(b8.req), 32'd0);
    chk("t6_ok_rst", 32'(b8.data_ok), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_miss_after", 32'(b8.data_ok), 32'd0);
    tick();
    chk("t6_rereq", 32'(b8.req), 32'd1);
    chk("t6_rera", 32'(b8.req_addr), 32'h000008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
